// File: rtl/lms_pkg.sv
// Shared types, constants and saturation helper for the LMS tap engine.
package lms_pkg;

  localparam int unsigned WIDTH_DEF    = 16;
  localparam int unsigned DEPTH_DEF    = 32;
  localparam int unsigned MU_SHIFT_DEF = 4;

  // Accumulator wide enough to sum DEPTH full-precision products without overflow.
  localparam int unsigned ACC_W = 2 * WIDTH_DEF + $clog2(DEPTH_DEF);

  typedef logic signed [WIDTH_DEF-1:0] sample_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILTER = 3'd1,
    ERROR  = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Clamp a signed value to the range of a w-bit two's-complement number.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int unsigned      w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      sat_to_width = hi;
    end else if (v < lo) begin
      sat_to_width = lo;
    end else begin
      sat_to_width = v;
    end
  endfunction

endpackage

// File: rtl/lms_mac.sv
// Shared signed multiplier: raw product for the FIR sum and a
// shift/add/saturate path for the weight update.
module lms_mac
  import lms_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHIFT = 19
) (
  input  logic signed [WIDTH-1:0]   a_i,
  input  logic signed [WIDTH-1:0]   b_i,
  input  logic signed [WIDTH-1:0]   c_i,
  output logic signed [2*WIDTH-1:0] prod_c,
  output logic signed [WIDTH-1:0]   upd_c
);

  logic signed [2*WIDTH-1:0] shifted;
  logic signed [63:0]        sum;
  logic signed [63:0]        sum_sat;
  logic [63-WIDTH:0]         unused_sat_bits;

  // Multiply, scale down by SHIFT (floor), add to c and saturate.
  always_comb begin
    prod_c  = (2*WIDTH)'(a_i) * (2*WIDTH)'(b_i);
    shifted = prod_c >>> SHIFT;
    sum     = 64'(c_i) + 64'(shifted);
    sum_sat = sat_to_width(sum, WIDTH);
    upd_c   = sum_sat[WIDTH-1:0];
  end

  assign unused_sat_bits = sum_sat[63:WIDTH];

endmodule

// File: rtl/lms_tap_engine.sv
// Serial LMS engine: snapshot taps, serial FIR, error, optional serial weight update.
module lms_tap_engine
  import lms_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned MU_SHIFT = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [DEPTH-1:0][WIDTH-1:0] tapped_delay,
  input  logic [WIDTH-1:0]            desired,
  input  logic                        adapt_en,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            y,
  output logic [WIDTH-1:0]            e,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DEPTH-1:0][WIDTH-1:0] weights
);

  localparam int unsigned ACC_LW = 2 * WIDTH + $clog2(DEPTH);
  localparam int unsigned CNT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic signed [ACC_LW-1:0]    acc_q, acc_d;
  logic [DEPTH-1:0][WIDTH-1:0] x_q, x_d;
  logic [DEPTH-1:0][WIDTH-1:0] w_q, w_d;
  logic signed [WIDTH-1:0]     d_q, d_d;
  logic signed [WIDTH-1:0]     y_q, y_d;
  logic signed [WIDTH-1:0]     e_q, e_d;
  logic                        adapt_q, adapt_d;
  logic                        in_ready_q, in_ready_d;
  logic                        out_valid_q, out_valid_d;

  logic signed [WIDTH-1:0]     mac_x_c, mac_w_c, mac_b_c, upd_c;
  logic signed [2*WIDTH-1:0]   prod_c;
  logic signed [ACC_LW-1:0]    acc_sh_c;
  logic signed [63:0]          y_sat_c, e_sat_c;
  logic signed [WIDTH-1:0]     y_new_c;
  logic [2*(63-WIDTH)+1:0]     unused_sat_bits;
  logic                        last_c;

  // MAC operands: weight for the FIR sum, latched error for the update.
  assign mac_x_c = x_q[cnt_q];
  assign mac_w_c = w_q[cnt_q];
  assign mac_b_c = (state_q == UPDATE) ? e_q : mac_w_c;
  assign last_c  = (cnt_q == CNT_W'(DEPTH - 1));

  lms_mac #(
    .WIDTH (WIDTH),
    .SHIFT (WIDTH - 1 + MU_SHIFT)
  ) u_mac (
    .a_i    (mac_x_c),
    .b_i    (mac_b_c),
    .c_i    (mac_w_c),
    .prod_c (prod_c),
    .upd_c  (upd_c)
  );

  // Output scaling of the accumulator and error formation.
  always_comb begin
    acc_sh_c = acc_q >>> (WIDTH - 1);
    y_sat_c  = sat_to_width(64'(acc_sh_c), WIDTH);
    y_new_c  = y_sat_c[WIDTH-1:0];
    e_sat_c  = sat_to_width(64'(d_q) - 64'(y_new_c), WIDTH);
  end

  assign unused_sat_bits = {y_sat_c[63:WIDTH], e_sat_c[63:WIDTH]};

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    x_d     = x_q;
    w_d     = w_q;
    d_d     = d_q;
    y_d     = y_q;
    e_d     = e_q;
    adapt_d = adapt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d     = tapped_delay;
          d_d     = desired;
          adapt_d = adapt_en;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = FILTER;
        end
      end
      FILTER: begin
        acc_d = acc_q + ACC_LW'(prod_c);
        if (last_c) begin
          cnt_d   = '0;
          state_d = ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERROR: begin
        y_d     = y_new_c;
        e_d     = e_sat_c[WIDTH-1:0];
        cnt_d   = '0;
        state_d = adapt_q ? UPDATE : DONE;
      end
      UPDATE: begin
        w_d[cnt_q] = upd_c;
        if (last_c) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_q == DONE) && (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      w_q         <= '0;
      d_q         <= '0;
      y_q         <= '0;
      e_q         <= '0;
      adapt_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      w_q         <= w_d;
      d_q         <= d_d;
      y_q         <= y_d;
      e_q         <= e_d;
      adapt_q     <= adapt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign e         = e_q;
  assign weights   = w_q;

endmodule

// File: tb/tb_lms_tap_engine.sv
// Directed bench for lms_tap_engine at WIDTH=16, DEPTH=4, MU_SHIFT=0.
module tb_lms_tap_engine;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MU_SHIFT = 0;

  logic                        clk;
  logic                        rstn;
  logic [DEPTH-1:0][WIDTH-1:0] tapped_delay;
  logic [WIDTH-1:0]            desired;
  logic                        adapt_en;
  logic                        in_valid;
  logic                        in_ready;
  logic [WIDTH-1:0]            y;
  logic [WIDTH-1:0]            e;
  logic                        out_valid;
  logic                        out_ready;
  logic [DEPTH-1:0][WIDTH-1:0] weights;

  int n_vec = 0;
  int n_bad = 0;

  lms_tap_engine #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .MU_SHIFT (MU_SHIFT)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .tapped_delay (tapped_delay),
    .desired      (desired),
    .adapt_en     (adapt_en),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .y            (y),
    .e            (e),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .weights      (weights)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DEPTH-1:0][WIDTH-1:0] taps;
    logic [WIDTH-1:0]            d;
    logic                        adapt;
    logic [WIDTH-1:0]            exp_y;
    logic [WIDTH-1:0]            exp_e;
    int                          exp_lat;
    logic [WIDTH-1:0]            exp_w0;
    logic [WIDTH-1:0]            exp_w1;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one sample, wait (bounded) for out_valid; optionally scramble inputs mid-run.
  task automatic run_sample(input logic [DEPTH-1:0][WIDTH-1:0] taps, input logic [WIDTH-1:0] d,
                            input logic ad, input bit scramble, output int lat);
    @(negedge clk);
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    tapped_delay = taps;
    desired      = d;
    adapt_en     = ad;
    in_valid     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_busy", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat <= 40) begin
      if (scramble && lat < 3) begin
        tapped_delay = {DEPTH{16'h7FFF}};
        desired      = 16'h8000;
        adapt_en     = 1'b1;
        in_valid     = (lat < 2);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_hs", 64'(out_valid), 64'd0);
    check("in_ready_after_hs", 64'(in_ready), 64'd1);
  endtask

  function automatic vec_t mk(input logic [WIDTH-1:0] t3, t2, t1, t0, input logic [WIDTH-1:0] d,
                              input logic ad, input logic [WIDTH-1:0] ey, ee, input int lat,
                              input logic [WIDTH-1:0] w0, w1);
    vec_t v;
    v.taps    = {t3, t2, t1, t0};
    v.d       = d;
    v.adapt   = ad;
    v.exp_y   = ey;
    v.exp_e   = ee;
    v.exp_lat = lat;
    v.exp_w0  = w0;
    v.exp_w1  = w1;
    return v;
  endfunction

  vec_t vecs[7];

  initial begin
    int lat;
    logic [DEPTH-1:0][WIDTH-1:0] t;

    vecs[0] = mk(16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h2000, 1'b0, 16'h0000, 16'h2000, 6,  16'h0000, 16'h0000);
    vecs[1] = mk(16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h4000, 1'b1, 16'h0000, 16'h4000, 10, 16'h2000, 16'h0000);
    vecs[2] = mk(16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h4000, 1'b1, 16'h1000, 16'h3000, 10, 16'h3800, 16'h0000);
    vecs[3] = mk(16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 1'b0, 16'h37FF, 16'h8000, 6,  16'h3800, 16'h0000);
    vecs[4] = mk(16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h1000, 1'b1, 16'h0000, 16'h1000, 10, 16'h3800, 16'h0800);
    vecs[5] = mk(16'h0000, 16'h0000, 16'h0000, 16'hC000, 16'h0000, 1'b0, 16'hE400, 16'h1C00, 6,  16'h3800, 16'h0800);
    vecs[6] = mk(16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 16'h0001, 6,  16'h3800, 16'h0800);

    rstn         = 1'b0;
    tapped_delay = '0;
    desired      = '0;
    adapt_en     = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_e", 64'(e), 64'd0);
    check("rst_weights", 64'(weights), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Table of back-to-back samples; weights carry over from one to the next.
    for (int i = 0; i < 7; i++) begin
      run_sample(vecs[i].taps, vecs[i].d, vecs[i].adapt, 1'b0, lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_y", i), 64'(y), 64'(vecs[i].exp_y));
      check($sformatf("v%0d_e", i), 64'(e), 64'(vecs[i].exp_e));
      check($sformatf("v%0d_w0", i), 64'(weights[0]), 64'(vecs[i].exp_w0));
      check($sformatf("v%0d_w1", i), 64'(weights[1]), 64'(vecs[i].exp_w1));
      check($sformatf("v%0d_w23", i), 64'({weights[3], weights[2]}), 64'd0);
      handshake();
    end

    // Backpressure: DONE held while in_valid pulses with fresh data.
    run_sample({16'h0000, 16'h0000, 16'h0000, 16'h4000}, 16'h0000, 1'b0, 1'b0, lat);
    check("bp_latency", 64'(lat), 64'd6);
    for (int c = 0; c < 10; c++) begin
      t[0] = 16'($urandom);
      t[1] = 16'($urandom);
      t[2] = 16'($urandom);
      t[3] = 16'($urandom);
      tapped_delay = t;
      desired      = 16'($urandom);
      adapt_en     = 1'b1;
      in_valid     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_y", 64'(y), 64'h1C00);
      check("bp_e", 64'(e), 64'hE400);
      check("bp_weights", 64'(weights), {16'h0000, 16'h0000, 16'h0800, 16'h3800});
    end
    in_valid = 1'b0;
    handshake();
    repeat (2) @(negedge clk);
    check("bp_no_accept", 64'(in_ready), 64'd1);

    // Snapshot: upstream changes during FILTER must not affect the result.
    run_sample({16'h0000, 16'h0000, 16'h0000, 16'h4000}, 16'h2000, 1'b0, 1'b1, lat);
    check("snap_latency", 64'(lat), 64'd6);
    check("snap_y", 64'(y), 64'h1C00);
    check("snap_e", 64'(e), 64'h0400);
    check("snap_weights", 64'(weights), {16'h0000, 16'h0000, 16'h0800, 16'h3800});
    handshake();
    repeat (2) @(negedge clk);
    check("snap_no_accept", 64'(in_ready), 64'd1);

    // Reset in the middle of UPDATE, right after tap 0 has been written.
    @(negedge clk);
    tapped_delay = {DEPTH{16'h4000}};
    desired      = 16'h4000;
    adapt_en     = 1'b1;
    in_valid     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("upd_w0_mid", 64'(weights[0]), 64'h4800);
    check("upd_w1_mid", 64'(weights[1]), 64'h0800);
    check("upd_e_mid", 64'(e), 64'h2000);
    rstn = 1'b0;
    #1;
    check("midrst_weights", 64'(weights), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_y", 64'(y), 64'd0);
    check("midrst_e", 64'(e), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Engine works from zeroed weights after reset.
    run_sample(vecs[0].taps, vecs[0].d, vecs[0].adapt, 1'b0, lat);
    check("post_rst_latency", 64'(lat), 64'd6);
    check("post_rst_y", 64'(y), 64'h0000);
    check("post_rst_e", 64'(e), 64'h2000);
    check("post_rst_weights", 64'(weights), 64'd0);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
